// File: rtl/piano_pkg.sv
// piano_pkg: shared types and constants for the piano note encoder.
// Key count, "no note" code, note code type, FSM states, width helper.
package piano_pkg;

  localparam int NUM_KEYS = 8;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_NONE = 4'hF;

`ifdef NOTE_SUSTAIN_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    SUSTAIN = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1
  } state_t;
`endif

  // Counter width for a counter that counts 0..n-1 (at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus counter debouncer for one key.
// Ports: clk, rst_n (async low), key (raw level), db (debounced level).
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic db
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // The debounced level only moves after DEBOUNCE_CYCLES
  // consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_encoder.sv
// note_encoder: debounced 8-key priority encoder with note FSM.
// Ports: clk, rst_n, key[7:0] -> note[3:0], note_change, playing.
// Optional macro NOTE_SUSTAIN_EN adds a SUSTAIN hold state.
module note_encoder
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SUSTAIN_CYCLES  = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output note_t               note,
  output logic                note_change,
  output logic                playing
);

  if (DEBOUNCE_CYCLES < 1 || SUSTAIN_CYCLES < 1) begin : g_bad_param
    $error("note_encoder: cycle parameters must be >= 1");
  end

  logic [NUM_KEYS-1:0] db;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .key  (key[i]),
      .db   (db[i])
    );
  end

  // Lowest pressed index wins.
  note_t win;
  logic  any;

  always_comb begin
    win = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (db[i]) win = note_t'(i);
    end
  end

  assign any = |db;

  state_t state;
  state_t state_n;
  note_t  note_n;

`ifdef NOTE_SUSTAIN_EN
  localparam int SCW = cnt_w(SUSTAIN_CYCLES);
  localparam logic [SCW-1:0] SLAST = SCW'(SUSTAIN_CYCLES - 1);

  logic [SCW-1:0] scnt;
  logic [SCW-1:0] scnt_n;
`endif

  always_comb begin
    state_n = state;
    note_n  = note;
`ifdef NOTE_SUSTAIN_EN
    scnt_n  = scnt;
`endif
    unique case (state)
      IDLE: begin
        note_n = NOTE_NONE;
        if (any) begin
          state_n = PLAY;
          note_n  = win;
        end
      end
      PLAY: begin
        if (any) begin
          note_n = win;
        end else begin
`ifdef NOTE_SUSTAIN_EN
          state_n = SUSTAIN;
          scnt_n  = '0;
`else
          state_n = IDLE;
          note_n  = NOTE_NONE;
`endif
        end
      end
`ifdef NOTE_SUSTAIN_EN
      SUSTAIN: begin
        if (any) begin
          state_n = PLAY;
          note_n  = win;
          scnt_n  = '0;
        end else if (scnt == SLAST) begin
          state_n = IDLE;
          note_n  = NOTE_NONE;
          scnt_n  = '0;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        note_n  = NOTE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      note        <= NOTE_NONE;
      note_change <= 1'b0;
      playing     <= 1'b0;
    end else begin
      state       <= state_n;
      note        <= note_n;
      note_change <= (note_n != note);
      playing     <= (note_n != NOTE_NONE);
    end
  end

`ifdef NOTE_SUSTAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt <= '0;
    else        scnt <= scnt_n;
  end
`endif

endmodule

// File: tb/tb_note_encoder.sv
// tb_note_encoder: randomized bench with behavioural model for note_encoder.
// Directed literal checks pin the model; compare runs every cycle.
module tb_note_encoder;

  localparam int D = 4;
  localparam int S = 10;
  localparam logic [3:0] NONE = 4'hF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key;
  logic [3:0] note;
  logic       note_change;
  logic       playing;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  note_encoder #(
    .DEBOUNCE_CYCLES(D),
    .SUSTAIN_CYCLES (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .note       (note),
    .note_change(note_change),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  // Behavioural model: a key counts as pressed/released once its
  // 2-cycle-delayed level has disagreed with the accepted level for
  // D edges in a row; the output reflects the accepted keys one
  // edge later.
  logic [7:0] d1 = '0;
  logic [7:0] d2 = '0;
  logic [7:0] mdb = '0;
  int         run [8];
  logic [3:0] mnote = NONE;
  logic [3:0] prev;
  logic [3:0] w;
  bit         mchg = 1'b0;
  bit         mplay = 1'b0;
  int         idle = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = '0;
      d2 = '0;
      mdb = '0;
      for (int i = 0; i < 8; i++) run[i] = 0;
      mnote = NONE;
      mchg = 1'b0;
      mplay = 1'b0;
      idle = 0;
    end else begin
      w = NONE;
      for (int i = 7; i >= 0; i--) if (mdb[i]) w = 4'(i);
      prev = mnote;
      if (w != NONE) begin
        mnote = w;
        idle = 0;
      end else if (mnote != NONE) begin
`ifdef NOTE_SUSTAIN_EN
        idle++;
        if (idle > S) mnote = NONE;
`else
        mnote = NONE;
`endif
      end
      mchg = (mnote != prev);
      mplay = (mnote != NONE);
      for (int i = 0; i < 8; i++) begin
        if (d2[i] != mdb[i]) begin
          run[i]++;
          if (run[i] == D) begin
            mdb[i] = d2[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      d2 = d1;
      d1 = key;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      tests++;
      if ({note, note_change, playing} !== {mnote, mchg, mplay}) begin
        fails++;
        $display("FAIL model t=%0t got note=%h chg=%b play=%b want note=%h chg=%b play=%b",
                 $time, note, note_change, playing, mnote, mchg, mplay);
      end
    end
  end

  task automatic chk(input string nm, input logic [5:0] got,
                     input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %h/%b/%b want %h/%b/%b", nm, $time,
               got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [5:0] ex(input logic [3:0] n, input bit c);
    return {n, c, n != NONE};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    key = '0;
    cyc(3);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // idle after reset with no keys
    for (int k = 1; k <= 50; k++) begin
      cyc(1);
      chk("idle", {note, note_change, playing}, ex(NONE, 0));
    end

    // key 2 held from reset release: note at edge 7 only
    rst_n = 1'b0;
    cyc(1);
    key = 8'h04;
    cyc(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk("lat", {note, note_change, playing},
          (k < 7) ? ex(NONE, 0) : ex(4'd2, k == 7));
    end

    // short glitch on key 0 is ignored
    key = 8'h00;
    cyc(25);
    chk("rel", {note, note_change, playing}, ex(NONE, 0));
    key = 8'h01;
    cyc(3);
    key = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk("glitch", {note, note_change, playing}, ex(NONE, 0));
    end

    // handover 2 -> 5 without a gap
    key = 8'h24;
    cyc(12);
    chk("hold24", {note, note_change, playing}, ex(4'd2, 0));
    key = 8'h20;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk("handover", {note, note_change, playing},
          (k < 7) ? ex(4'd2, 0) : ex(4'd5, k == 7));
    end

`ifdef NOTE_SUSTAIN_EN
    // sustain expiry
    key = 8'h00;
    cyc(25);
    key = 8'h01;
    cyc(12);
    key = 8'h00;
    for (int k = 1; k <= 18; k++) begin
      cyc(1);
      chk("sustain", {note, note_change, playing},
          (k < 17) ? ex(4'd0, 0) : ex(NONE, k == 17));
    end
    // press during sustain
    key = 8'h01;
    cyc(12);
    key = 8'h00;
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      if (k == 5) key = 8'h80;
      chk("sus_press", {note, note_change, playing},
          (k < 12) ? ex(4'd0, 0) : ex(4'd7, k == 12));
    end
`endif

    // async reset during play, then re-qualify
    key = 8'h10;
    cyc(20);
    chk("hold10", {note, note_change, playing}, ex(4'd4, 0));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {note, note_change, playing}, ex(NONE, 0));
    cyc(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk("requal", {note, note_change, playing},
          (k < 7) ? ex(NONE, 0) : ex(4'd4, k == 7));
    end

    // randomized phase
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 3))
        0: key = '0;
        1: key = 8'(1 << $urandom_range(0, 7));
        2: key = 8'($urandom);
        default: key = key ^ 8'(1 << $urandom_range(0, 7));
      endcase
      cyc($urandom_range(1, 12));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_encoder.md
NOTE_ENCODER -- requirements
Module: note_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable samples needed to accept a key level change.
REQ-002 Parameter SUSTAIN_CYCLES, default 5000000: cycles the last note is held after release (sustain build only).
REQ-003 clk  input  1  single system clock; all state is on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 key  input  8  raw asynchronous piano key/switch levels; 1 = pressed; key[i] maps to note code i.
REQ-006 note  output  4  current note code: 0..7, or 4'hF = none.
REQ-007 note_change  output  1  one-cycle pulse on any change of note.
REQ-008 playing  output  1  high whenever note != 4'hF.

Function
REQ-009 Each key bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each synchronized bit SHALL be debounced by a per-key counter: the counter clears whenever sample == debounced state; otherwise it increments; the debounced state takes the sample when the count reaches DEBOUNCE_CYCLES-1.
REQ-011 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced state unchanged.
REQ-012 The lowest-index pressed debounced key SHALL win; simultaneous presses resolve by index only.
REQ-013 The FSM SHALL have states IDLE, PLAY, and SUSTAIN (sustain build only).
REQ-014 IDLE -> PLAY when any debounced key is pressed; note <= winning index.
REQ-015 In PLAY, note SHALL track the winner each cycle; releasing the winner while another key is held moves note to the new winner with no 4'hF gap.
REQ-016 PLAY with all keys released -> IDLE (note <= 4'hF), or -> SUSTAIN in the sustain build.
REQ-017 Latency: raw key edge held stable -> note updated exactly DEBOUNCE_CYCLES+3 cycles later (2 sync, DEBOUNCE_CYCLES debounce, 1 output register).
REQ-018 note, note_change and playing SHALL be registered outputs; note_change SHALL be high in exactly the cycle the new note value first appears.
REQ-019 note SHALL never take values 8..14.

Reset
REQ-020 While rst_n = 0: note = 4'hF, note_change = 0, playing = 0, FSM = IDLE, all debounce counters = 0, debounced states = 0, synchronizers = 0.
REQ-021 Reset asserted mid-press or mid-sustain SHALL abort immediately; after release, a held key SHALL re-qualify with the full REQ-017 latency.

Configuration
REQ-022 Macro NOTE_SUSTAIN_EN: when defined, SUSTAIN state and a sustain counter are built in.
REQ-023 With NOTE_SUSTAIN_EN: on full release, note holds its last value for SUSTAIN_CYCLES cycles, then becomes 4'hF with a note_change pulse; any press during SUSTAIN -> PLAY immediately with the new winner, and the counter is cleared.
REQ-024 Without NOTE_SUSTAIN_EN: no SUSTAIN state or counter; full release gives 4'hF on the next cycle.

Structure
REQ-025 Shared package piano_pkg SHALL hold NUM_KEYS = 8, NOTE_NONE = 4'hF, the note code type (4 bits), and the FSM state enum.
REQ-026 Synchronizer and debounce SHALL be one sub-module, key_debounce, instantiated once per key; priority encoder and FSM stay in note_encoder.
REQ-027 Counter widths SHALL be clog2 of the corresponding parameter.

Verification (DEBOUNCE_CYCLES = 4, SUSTAIN_CYCLES = 10)
REQ-028 Reset release, key = 0 -> note = 4'hF, playing = 0, no note_change pulses for 50 cycles.
REQ-029 key = 8'h04 held from cycle 0 -> note = 2, playing = 1 and note_change pulse at cycle 7 only.
REQ-030 key[0] pulsed for 3 cycles -> note stays 4'hF throughout.
REQ-031 key = 8'h24 stable, then key[2] released -> note 2 -> 5 directly, one note_change pulse, no 4'hF gap.
REQ-032 Sustain build, key 8'h01 pressed then released -> note = 0 for 10 cycles after the release is accepted, then 4'hF with a pulse; repeat with key 8'h80 pressed at sustain cycle 5 -> note = 7 without passing through 4'hF.
REQ-033 rst_n pulsed low during PLAY with key 8'h10 held -> outputs reach reset values asynchronously; note = 4 again 7 cycles after rst_n rises.
